// File: rtl/call_stack_lifo.sv
// Hardware LIFO for PSH/POP with a registered top-of-stack output.
// Optional sticky overflow/underflow flags are enabled by defining STACK_ERR_FLAGS_EN.
module call_stack_lifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pushEn,
  input  logic             popEn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             stackFull,
  output logic             stackEmpty,
`ifdef STACK_ERR_FLAGS_EN
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] top_q;
  logic [CNT_W-1:0] cnt_q;
  logic             empty, full;
  logic             do_push, do_pop, do_repl, ovf_evt, unf_evt;
  logic [CNT_W-1:0] cnt_m1, cnt_m2;
  logic [AW-1:0]    wr_idx;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign cnt_m1 = cnt_q - CNT_W'(1);
  assign cnt_m2 = cnt_q - CNT_W'(2);

  // Push+pop on a non-empty stack overwrites the top; on an empty stack it is a plain push.
  always_comb begin
    do_repl = pushEn && popEn && !empty;
    do_push = pushEn && (!popEn || empty) && !full;
    do_pop  = popEn && !pushEn && !empty;
    ovf_evt = pushEn && !popEn && full;
    unf_evt = popEn && !pushEn && empty;
    wr_idx  = do_repl ? cnt_m1[AW-1:0] : cnt_q[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset && (do_push || do_repl))
      mem[wr_idx] <= din;
  end

  // The top is kept in its own register so dout never depends on this cycle's inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      top_q <= '0;
    end else if (do_push) begin
      cnt_q <= cnt_q + CNT_W'(1);
      top_q <= din;
    end else if (do_repl) begin
      top_q <= din;
    end else if (do_pop) begin
      cnt_q <= cnt_m1;
      top_q <= (cnt_q >= CNT_W'(2)) ? mem[cnt_m2[AW-1:0]] : '0;
    end
  end

`ifdef STACK_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  // Clear first, then set, so a new error in the clear cycle survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (err_clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      if (ovf_evt) ovf_q <= 1'b1;
      if (unf_evt) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_evt;
  assign unused_evt = ovf_evt ^ unf_evt;
`endif

  assign dout       = top_q;
  assign count      = cnt_q;
  assign stackEmpty = empty;
  assign stackFull  = full;

endmodule
